// File: rtl/gray_threshold_binarizer_if.sv
// Stream bundle for the grayscale-to-binary thresholding stage: grayscale input,
// threshold programming, and the tagged binary output stream.
interface gray_threshold_binarizer_if #(
    parameter int CW = 4,
    parameter int RW = 4
);
    logic [7:0]    thresh_in;
    logic          thresh_load;
    logic [7:0]    gray_pixel;
    logic          gray_valid;
    logic          gray_ready;
    logic [7:0]    binary_image_pixel;
    logic          bin_valid;
    logic          bin_ready;
    logic          bin_sof;
    logic          bin_eol;
    logic          bin_eof;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic          frame_done;
    logic [15:0]   frame_count;

    modport slave (
        input  thresh_in, thresh_load, gray_pixel, gray_valid, bin_ready,
        output gray_ready, binary_image_pixel, bin_valid, bin_sof, bin_eol, bin_eof,
               row_idx, col_idx, frame_done, frame_count
    );

    modport master (
        output thresh_in, thresh_load, gray_pixel, gray_valid, bin_ready,
        input  gray_ready, binary_image_pixel, bin_valid, bin_sof, bin_eol, bin_eof,
               row_idx, col_idx, frame_done, frame_count
    );
endinterface

// File: rtl/gray_threshold_binarizer.sv
// Thresholds a raster stream of 8-bit gray pixels to 0x00/0xFF through a single
// output register stage, tagging each pixel with its raster position and frame markers.
module gray_threshold_binarizer #(
    parameter int          WIDTH          = 10,
    parameter int          HEIGHT         = 10,
    parameter logic [7:0]  DEFAULT_THRESH = 8'd128,
    parameter int          CW             = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    parameter int          RW             = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    gray_threshold_binarizer_if.slave     bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic [7:0]    active_thresh_reg;
    logic [7:0]    pending_thresh_reg;
    logic [7:0]    thresh_eff;
    logic [7:0]    pixel_reg;
    logic          valid_reg;
    logic          sof_reg, eol_reg, eof_reg;
    logic [RW-1:0] row_idx_reg;
    logic [CW-1:0] col_idx_reg;
    logic          frame_done_reg;
    logic [15:0]   frame_count_reg;

    logic ready;
    logic accept;
    logic xfer;
    logic last_col, last_row;

    assign ready    = !valid_reg || bus.bin_ready;
    assign accept   = bus.gray_valid && ready;
    assign xfer     = valid_reg && bus.bin_ready;
    assign last_col = (col_reg == CW'(WIDTH - 1));
    assign last_row = (row_reg == RW'(HEIGHT - 1));

    // At a frame boundary the pending value (or a same-cycle load) governs the new frame.
    always_comb begin
        thresh_eff = active_thresh_reg;
        if (state_reg == IDLE)
            thresh_eff = bus.thresh_load ? bus.thresh_in : pending_thresh_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && !(last_col && last_row)) state_next = ACTIVE;
            ACTIVE:  if (accept && last_col && last_row)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_thresh_reg  <= DEFAULT_THRESH;
            pending_thresh_reg <= DEFAULT_THRESH;
        end else begin
            if (bus.thresh_load)
                pending_thresh_reg <= bus.thresh_in;
            if (accept && state_reg == IDLE)
                active_thresh_reg <= thresh_eff;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_reg <= '0;
                row_reg <= last_row ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_reg   <= '0;
            valid_reg   <= 1'b0;
            sof_reg     <= 1'b0;
            eol_reg     <= 1'b0;
            eof_reg     <= 1'b0;
            row_idx_reg <= '0;
            col_idx_reg <= '0;
        end else if (accept) begin
            pixel_reg   <= (bus.gray_pixel >= thresh_eff) ? 8'hFF : 8'h00;
            valid_reg   <= 1'b1;
            sof_reg     <= (row_reg == '0) && (col_reg == '0);
            eol_reg     <= last_col;
            eof_reg     <= last_col && last_row;
            row_idx_reg <= row_reg;
            col_idx_reg <= col_reg;
        end else if (bus.bin_ready) begin
            valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            frame_done_reg <= xfer && eof_reg;
            if (xfer && eof_reg)
                frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    assign bus.gray_ready         = ready;
    assign bus.binary_image_pixel = pixel_reg;
    assign bus.bin_valid          = valid_reg;
    assign bus.bin_sof            = sof_reg;
    assign bus.bin_eol            = eol_reg;
    assign bus.bin_eof            = eof_reg;
    assign bus.row_idx            = row_idx_reg;
    assign bus.col_idx            = col_idx_reg;
    assign bus.frame_done         = frame_done_reg;
    assign bus.frame_count        = frame_count_reg;
endmodule

// File: tb/tb_gray_threshold_binarizer.sv
// Directed and scoreboard-checked bench for gray_threshold_binarizer (10x10 frames).
module tb_gray_threshold_binarizer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_threshold_binarizer_if #(.CW(4), .RW(4)) bus();

    gray_threshold_binarizer #(
        .WIDTH(10), .HEIGHT(10), .DEFAULT_THRESH(8'd128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] gray;
        logic [7:0] exp_pix;
    } vec_t;

    typedef struct {
        logic [7:0] pix;
        logic       sof, eol, eof;
        int         row, col;
    } sb_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tags come from the pixel's index within a 10x10 frame.
    task automatic check_out(input int idx, input logic [7:0] exp_pix);
        int r;
        int c;
        r = idx / 10;
        c = idx % 10;
        chk($sformatf("valid[%0d]", idx), bus.bin_valid, 1);
        chk($sformatf("pixel[%0d]", idx), bus.binary_image_pixel, exp_pix);
        chk($sformatf("sof[%0d]", idx), bus.bin_sof, (idx == 0));
        chk($sformatf("eol[%0d]", idx), bus.bin_eol, (c == 9));
        chk($sformatf("eof[%0d]", idx), bus.bin_eof, (idx == 99));
        chk($sformatf("row[%0d]", idx), bus.row_idx, r);
        chk($sformatf("col[%0d]", idx), bus.col_idx, c);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        sb_t  sb[$];
        sb_t  e;
        logic [7:0] v;
        int acc, xf, dones, cyc;

        tbl[0] = '{8'd127, 8'h00};
        tbl[1] = '{8'd128, 8'hFF};
        tbl[2] = '{8'd255, 8'hFF};
        tbl[3] = '{8'd0,   8'h00};
        tbl[4] = '{8'd129, 8'hFF};
        tbl[5] = '{8'd1,   8'h00};

        bus.thresh_in   = 8'h00;
        bus.thresh_load = 1'b0;
        bus.gray_pixel  = 8'h00;
        bus.gray_valid  = 1'b0;
        bus.bin_ready   = 1'b1;
        rst             = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", bus.bin_valid, 0);
        chk("rst_pixel", bus.binary_image_pixel, 0);
        chk("rst_sof", bus.bin_sof, 0);
        chk("rst_eof", bus.bin_eof, 0);
        chk("rst_row", bus.row_idx, 0);
        chk("rst_col", bus.col_idx, 0);
        chk("rst_done", bus.frame_done, 0);
        chk("rst_count", bus.frame_count, 0);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_gray_ready", bus.gray_ready, 1);

        // Frame 1: back-to-back stream, threshold table at the front
        for (int i = 0; i < 100; i++) begin
            if (i < 6) begin
                bus.gray_pixel = tbl[i].gray;
                v = tbl[i].exp_pix;
            end else begin
                bus.gray_pixel = 8'((i * 37 + 11) % 256);
                v = (bus.gray_pixel >= 8'd128) ? 8'hFF : 8'h00;
            end
            bus.gray_valid = 1'b1;
            chk($sformatf("f1_ready[%0d]", i), bus.gray_ready, 1);
            tick();
            check_out(i, v);
        end
        bus.gray_valid = 1'b0;
        tick();
        chk("f1_done", bus.frame_done, 1);
        chk("f1_count", bus.frame_count, 1);
        chk("f1_drain_valid", bus.bin_valid, 0);
        tick();
        chk("f1_done_pulse_end", bus.frame_done, 0);

        // Frame 2 with a mid-frame threshold load at (3,5); frame 3 start uses it
        for (int i = 0; i < 110; i++) begin
            bus.gray_pixel  = 8'h50;
            bus.gray_valid  = 1'b1;
            bus.thresh_in   = 8'h40;
            bus.thresh_load = (i == 35);
            tick();
            bus.thresh_load = 1'b0;
            chk($sformatf("thr_pixel[%0d]", i), bus.binary_image_pixel, (i < 100) ? 8'h00 : 8'hFF);
            chk($sformatf("thr_sof[%0d]", i), bus.bin_sof, (i % 100 == 0));
            if (i == 100) chk("f2_count", bus.frame_count, 2);
        end

        // Empty output register, then 5 cycles of backpressure
        bus.gray_valid = 1'b0;
        tick();
        chk("bp_idle_valid", bus.bin_valid, 0);
        bus.gray_valid = 1'b1;
        bus.bin_ready  = 1'b0;
        #1;
        chk("bp_ready_c1", bus.gray_ready, 1);
        tick();
        chk("bp_ready_c2", bus.gray_ready, 0);
        check_out(10, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("bp_ready_hold[%0d]", k), bus.gray_ready, 0);
            check_out(10, 8'hFF);
        end
        bus.bin_ready = 1'b1;
        tick();
        check_out(11, 8'hFF);
        for (int i = 12; i < 100; i++) begin
            tick();
            check_out(i, 8'hFF);
        end
        bus.gray_valid = 1'b0;
        tick();
        chk("f3_done", bus.frame_done, 1);
        chk("f3_count", bus.frame_count, 3);

        // Frame 4 interrupted by an asynchronous reset at (6,2)
        bus.gray_valid = 1'b1;
        for (int i = 0; i < 63; i++) begin
            tick();
            check_out(i, 8'hFF);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", bus.bin_valid, 0);
        chk("arst_count", bus.frame_count, 0);
        chk("arst_row", bus.row_idx, 0);
        chk("arst_col", bus.col_idx, 0);
        @(negedge clk) rst = 1'b1;
        #1;

        // Frame 5: restarts at (0,0) with the default threshold again
        for (int i = 0; i < 100; i++) begin
            tick();
            check_out(i, 8'h00);
        end

        // Frame 6: threshold load coinciding with the sof accept is used directly
        bus.thresh_in   = 8'h60;
        bus.thresh_load = 1'b1;
        bus.gray_pixel  = 8'h60;
        tick();
        bus.thresh_load = 1'b0;
        check_out(0, 8'hFF);
        chk("f5_count", bus.frame_count, 1);
        bus.gray_pixel = 8'h5F;
        tick();
        check_out(1, 8'h00);
        bus.gray_pixel = 8'h60;
        tick();
        check_out(2, 8'hFF);

        // Random valid/ready over 3 frames against a scoreboard
        bus.gray_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        #1;
        acc = 0; xf = 0; dones = 0; cyc = 0;
        while ((acc < 300 || xf < 300) && cyc < 6000) begin
            bus.gray_valid = (acc < 300) && ($urandom_range(0, 1) == 1);
            bus.bin_ready  = ($urandom_range(0, 1) == 1);
            bus.gray_pixel = 8'($urandom_range(0, 255));
            #1;
            if (bus.bin_valid && bus.bin_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_xfer", xf, 300);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rnd_pixel[%0d]", xf), bus.binary_image_pixel, e.pix);
                    chk($sformatf("rnd_sof[%0d]", xf), bus.bin_sof, e.sof);
                    chk($sformatf("rnd_eol[%0d]", xf), bus.bin_eol, e.eol);
                    chk($sformatf("rnd_eof[%0d]", xf), bus.bin_eof, e.eof);
                    chk($sformatf("rnd_row[%0d]", xf), bus.row_idx, e.row);
                    chk($sformatf("rnd_col[%0d]", xf), bus.col_idx, e.col);
                end
                xf++;
            end
            if (bus.gray_valid && bus.gray_ready) begin
                e.pix = (bus.gray_pixel >= 8'd128) ? 8'hFF : 8'h00;
                e.row = (acc % 100) / 10;
                e.col = acc % 10;
                e.sof = (acc % 100 == 0);
                e.eol = (e.col == 9);
                e.eof = (acc % 100 == 99);
                sb.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (bus.frame_done) dones++;
        end
        chk("rnd_in_budget", (cyc < 6000), 1);
        chk("rnd_xfers", xf, 300);
        chk("rnd_sb_empty", sb.size(), 0);
        chk("rnd_count", bus.frame_count, 3);
        chk("rnd_done_pulses", dones, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
